// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the execute stage (ALUOp codes, R-type funct
// values, multiplier FSM states, default widths) and the ALU operation decoder.
package ex_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int PC_W_DEF   = 8;

    // ALUOp encodings from the decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    // R-type funct field values
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_MULT = 6'b011000;

    // Sequential multiplier states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DONE = 2'b10
    } mul_state_e;

    // Internal ALU operation after ALUOp/funct decode
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_SLT = 3'd4,
        OP_MUL = 3'd5,
        OP_BAD = 3'd6
    } alu_op_e;

    // Map ALUOp plus funct to an ALU operation; the reserved ALUOp behaves as add
    function automatic alu_op_e decode_op(input logic [1:0] aluop, input logic [5:0] funct);
        alu_op_e op;
        case (aluop)
            ALUOP_ADD: op = OP_ADD;
            ALUOP_SUB: op = OP_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD:  op = OP_ADD;
                    FUNCT_SUB:  op = OP_SUB;
                    FUNCT_AND:  op = OP_AND;
                    FUNCT_OR:   op = OP_OR;
                    FUNCT_SLT:  op = OP_SLT;
                    FUNCT_MULT: op = OP_MUL;
                    default:    op = OP_BAD;
                endcase
            end
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ex_stage_seq_multiplier.sv
// seq_multiplier: shift-add multiplier, one partial product per cycle.
// IDLE -> MUL (MUL_CYCLES iterations) -> DONE -> IDLE. last_o flags the final
// iteration so the caller can capture product_o (the accumulator including
// that final addition) on the same edge the FSM enters DONE.
module seq_multiplier
    import ex_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MUL_CYCLES = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DATA_W-1:0] mcand_i,
    input  logic [DATA_W-1:0] mplier_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              last_o,
    output logic [DATA_W-1:0] product_o
);

    localparam int CNT_W = $clog2(MUL_CYCLES) + 1;

    mul_state_e        state_q;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;
    logic [CNT_W-1:0]  cnt_q;

    // Next accumulator value: add the shifted multiplicand when the multiplier LSB is set
    always_comb begin
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end else begin
            acc_d = acc_q;
        end
    end

    // Status outputs decoded from the state register
    always_comb begin
        busy_o    = (state_q == MUL);
        done_o    = (state_q == DONE);
        last_o    = (state_q == MUL) && (cnt_q == CNT_W'(MUL_CYCLES - 1));
        product_o = acc_d;
    end

    // Multiplier FSM and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mcand_q  <= mcand_i;
                        mplier_q <= mplier_i;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= MUL;
                    end
                end
                MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage. ALU, branch resolution, EX/MEM pipeline register
// and a multi-cycle multiplier that stalls the front of the pipe.
// Optional build macro EX_FORWARD_EN adds MEM/WB forwarding inputs. The ID/EX
// bundle carries only the rt address (ID_EX_Rb), so forwarding applies to the
// rt-sourced operand; the rs operand always comes from ID_EX_ReadData1.
module ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int PC_W       = PC_W_DEF,
    parameter int MUL_CYCLES = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ID_EX_ReadData1,
    input  logic [DATA_W-1:0] ID_EX_ReadData2,
    input  logic [DATA_W-1:0] ID_EX_SignExtImm,
    input  logic [4:0]        ID_EX_Rb,
    input  logic [4:0]        ID_EX_Rd,
    input  logic [PC_W-1:0]   ID_EX_PC,
    input  logic              ID_EX_RegDst,
    input  logic              ID_EX_ALUSrc,
    input  logic              ID_EX_MemToReg,
    input  logic              ID_EX_RegWrite,
    input  logic              ID_EX_MemRead,
    input  logic              ID_EX_MemWrite,
    input  logic              ID_EX_Branch,
    input  logic [1:0]        ID_EX_ALUOp,
    output logic              EX_Stall,
    output logic              BranchTaken,
    output logic [PC_W-1:0]   BranchTarget,
    output logic [DATA_W-1:0] EX_MEM_ALUResult,
    output logic [DATA_W-1:0] EX_MEM_WriteData,
    output logic [4:0]        EX_MEM_WriteReg,
    output logic              EX_MEM_MemToReg,
    output logic              EX_MEM_RegWrite,
    output logic              EX_MEM_MemRead,
    output logic              EX_MEM_MemWrite
`ifdef EX_FORWARD_EN
    ,
    input  logic              MEM_RegWrite,
    input  logic [4:0]        MEM_WriteReg,
    input  logic [DATA_W-1:0] MEM_ALUResult,
    input  logic              WB_RegWrite,
    input  logic [4:0]        WB_writeReg,
    input  logic [DATA_W-1:0] WB_writeData
`endif
);

    alu_op_e           op_s;
    logic [DATA_W-1:0] opa_s;
    logic [DATA_W-1:0] rt_s;
    logic [DATA_W-1:0] opb_s;
    logic [DATA_W-1:0] alu_res_s;
    logic              alu_ok_s;
    logic              zero_s;
    logic [4:0]        wreg_s;
    logic [7:0]        br_off_s;
    logic [PC_W-1:0]   target_s;
    logic              is_mul_s;
    logic              issue_mul_s;

    logic              mul_busy_s;
    logic              mul_done_s;
    logic              mul_last_s;
    logic [DATA_W-1:0] mul_product_s;

    logic [4:0]        lat_wreg_q;
    logic              lat_memtoreg_q;
    logic              lat_regwrite_q;
    logic              lat_memread_q;
    logic              lat_memwrite_q;

`ifdef EX_FORWARD_EN
    // rt operand source: MEM result wins over WB, register 0 is never forwarded
    always_comb begin
        if (MEM_RegWrite && (MEM_WriteReg != 5'd0) && (MEM_WriteReg == ID_EX_Rb)) begin
            rt_s = MEM_ALUResult;
        end else if (WB_RegWrite && (WB_writeReg != 5'd0) && (WB_writeReg == ID_EX_Rb)) begin
            rt_s = WB_writeData;
        end else begin
            rt_s = ID_EX_ReadData2;
        end
    end
`else
    // rt operand taken straight from the ID/EX bundle
    always_comb begin
        rt_s = ID_EX_ReadData2;
    end
`endif

    // Operand selection, destination register, branch target and op decode
    always_comb begin
        opa_s    = ID_EX_ReadData1;
        opb_s    = ID_EX_ALUSrc ? ID_EX_SignExtImm : rt_s;
        wreg_s   = ID_EX_RegDst ? ID_EX_Rd : ID_EX_Rb;
        br_off_s = {ID_EX_SignExtImm[5:0], 2'b00};
        target_s = ID_EX_PC + PC_W'(br_off_s);
        zero_s   = ((opa_s - rt_s) == {DATA_W{1'b0}});
        op_s     = decode_op(ID_EX_ALUOp, ID_EX_SignExtImm[5:0]);
        is_mul_s = (op_s == OP_MUL);
    end

    // Single-cycle ALU; an unknown funct yields 0 and suppresses the register write
    always_comb begin
        alu_res_s = '0;
        alu_ok_s  = 1'b1;
        case (op_s)
            OP_ADD: alu_res_s = opa_s + opb_s;
            OP_SUB: alu_res_s = opa_s - opb_s;
            OP_AND: alu_res_s = opa_s & opb_s;
            OP_OR:  alu_res_s = opa_s | opb_s;
            OP_SLT: alu_res_s = {{(DATA_W-1){1'b0}}, ($signed(opa_s) < $signed(opb_s))};
            OP_MUL: alu_res_s = '0;
            default: begin
                alu_res_s = '0;
                alu_ok_s  = 1'b0;
            end
        endcase
    end

    // A mult is accepted only while the multiplier sits in IDLE
    always_comb begin
        if (mul_busy_s || mul_done_s) begin
            issue_mul_s = 1'b0;
        end else begin
            issue_mul_s = is_mul_s;
        end
    end

    // Stall from the issue cycle through the last MUL cycle; forced low during reset
    always_comb begin
        if (rst) begin
            EX_Stall = 1'b0;
        end else if (mul_busy_s) begin
            EX_Stall = 1'b1;
        end else begin
            EX_Stall = issue_mul_s;
        end
    end

    seq_multiplier #(
        .DATA_W     (DATA_W),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (issue_mul_s),
        .mcand_i   (opa_s),
        .mplier_i  (opb_s),
        .busy_o    (mul_busy_s),
        .done_o    (mul_done_s),
        .last_o    (mul_last_s),
        .product_o (mul_product_s)
    );

    // Hold the mult's destination and control until its result is written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_wreg_q     <= 5'd0;
            lat_memtoreg_q <= 1'b0;
            lat_regwrite_q <= 1'b0;
            lat_memread_q  <= 1'b0;
            lat_memwrite_q <= 1'b0;
        end else if (issue_mul_s) begin
            lat_wreg_q     <= wreg_s;
            lat_memtoreg_q <= ID_EX_MemToReg;
            lat_regwrite_q <= ID_EX_RegWrite;
            lat_memread_q  <= ID_EX_MemRead;
            lat_memwrite_q <= ID_EX_MemWrite;
        end
    end

    // EX/MEM pipeline register plus registered branch decision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            EX_MEM_ALUResult <= '0;
            EX_MEM_WriteData <= '0;
            EX_MEM_WriteReg  <= 5'd0;
            EX_MEM_MemToReg  <= 1'b0;
            EX_MEM_RegWrite  <= 1'b0;
            EX_MEM_MemRead   <= 1'b0;
            EX_MEM_MemWrite  <= 1'b0;
            BranchTaken      <= 1'b0;
            BranchTarget     <= '0;
        end else if (mul_last_s) begin
            EX_MEM_ALUResult <= mul_product_s;
            EX_MEM_WriteData <= '0;
            EX_MEM_WriteReg  <= lat_wreg_q;
            EX_MEM_MemToReg  <= lat_memtoreg_q;
            EX_MEM_RegWrite  <= lat_regwrite_q;
            EX_MEM_MemRead   <= lat_memread_q;
            EX_MEM_MemWrite  <= lat_memwrite_q;
            BranchTaken      <= 1'b0;
            BranchTarget     <= '0;
        end else if (mul_busy_s || mul_done_s || issue_mul_s) begin
            EX_MEM_ALUResult <= '0;
            EX_MEM_WriteData <= '0;
            EX_MEM_WriteReg  <= 5'd0;
            EX_MEM_MemToReg  <= 1'b0;
            EX_MEM_RegWrite  <= 1'b0;
            EX_MEM_MemRead   <= 1'b0;
            EX_MEM_MemWrite  <= 1'b0;
            BranchTaken      <= 1'b0;
            BranchTarget     <= '0;
        end else begin
            EX_MEM_ALUResult <= alu_res_s;
            EX_MEM_WriteData <= rt_s;
            EX_MEM_WriteReg  <= wreg_s;
            EX_MEM_MemToReg  <= ID_EX_MemToReg;
            EX_MEM_RegWrite  <= ID_EX_RegWrite & alu_ok_s & ~ID_EX_Branch;
            EX_MEM_MemRead   <= ID_EX_MemRead & ~ID_EX_Branch;
            EX_MEM_MemWrite  <= ID_EX_MemWrite & ~ID_EX_Branch;
            BranchTaken      <= ID_EX_Branch & zero_s;
            BranchTarget     <= target_s;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized + directed bench for ex_stage. The driver pushes the
// expected per-cycle observation into a queue; a negedge monitor pops and
// compares. Expectations come from an instruction-level reference model.
module tb_ex_stage;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rb;
        logic [4:0]  rd;
        logic [7:0]  pc;
        logic        regdst;
        logic        alusrc;
        logic        memtoreg;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        branch;
        logic [1:0]  aluop;
    } instr_t;

    typedef struct packed {
        logic        stall;
        logic        chk_data;
        logic        chk_wdata;
        logic        chk_tgt;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  wreg;
        logic        memtoreg;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        btaken;
        logic [7:0]  btgt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rb, rd;
    logic [7:0]  pc;
    logic        regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch;
    logic [1:0]  aluop;
    logic        stall, btaken;
    logic [7:0]  btgt;
    logic [31:0] o_alu, o_wdata;
    logic [4:0]  o_wreg;
    logic        o_memtoreg, o_regwrite, o_memread, o_memwrite;

    exp_t exp_q[$];
    exp_t pending;
    exp_t zero_e;
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    ex_stage dut (
        .clk              (clk),
        .rst              (rst),
        .ID_EX_ReadData1  (rd1),
        .ID_EX_ReadData2  (rd2),
        .ID_EX_SignExtImm (imm),
        .ID_EX_Rb         (rb),
        .ID_EX_Rd         (rd),
        .ID_EX_PC         (pc),
        .ID_EX_RegDst     (regdst),
        .ID_EX_ALUSrc     (alusrc),
        .ID_EX_MemToReg   (memtoreg),
        .ID_EX_RegWrite   (regwrite),
        .ID_EX_MemRead    (memread),
        .ID_EX_MemWrite   (memwrite),
        .ID_EX_Branch     (branch),
        .ID_EX_ALUOp      (aluop),
        .EX_Stall         (stall),
        .BranchTaken      (btaken),
        .BranchTarget     (btgt),
        .EX_MEM_ALUResult (o_alu),
        .EX_MEM_WriteData (o_wdata),
        .EX_MEM_WriteReg  (o_wreg),
        .EX_MEM_MemToReg  (o_memtoreg),
        .EX_MEM_RegWrite  (o_regwrite),
        .EX_MEM_MemRead   (o_memread),
        .EX_MEM_MemWrite  (o_memwrite)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", name, $time, act, expv);
        end
    endtask

    // Monitor: one expected observation per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("stall",    32'(stall),      32'(mon_e.stall));
            check("regwrite", 32'(o_regwrite), 32'(mon_e.regwrite));
            check("memread",  32'(o_memread),  32'(mon_e.memread));
            check("memwrite", 32'(o_memwrite), 32'(mon_e.memwrite));
            check("memtoreg", 32'(o_memtoreg), 32'(mon_e.memtoreg));
            check("btaken",   32'(btaken),     32'(mon_e.btaken));
            if (mon_e.chk_data) begin
                check("aluresult", o_alu,         mon_e.alu);
                check("writereg",  32'(o_wreg),   32'(mon_e.wreg));
            end
            if (mon_e.chk_wdata) check("writedata", o_wdata, mon_e.wdata);
            if (mon_e.chk_tgt)   check("btarget", 32'(btgt), 32'(mon_e.btgt));
        end
    end

    function automatic logic [31:0] opb(input instr_t in);
        return in.alusrc ? in.imm : in.rd2;
    endfunction

    function automatic bit is_mult(input instr_t in);
        logic [5:0] f;
        f = in.imm[5:0];
        return (in.aluop == 2'b10) && (f == 6'b011000);
    endfunction

    // Reference: what EX/MEM should hold one edge after a single-cycle instruction
    function automatic exp_t model(input instr_t in);
        exp_t        e;
        logic [31:0] a, b;
        logic [5:0]  f;
        e           = '0;
        e.chk_data  = 1'b1;
        e.chk_wdata = 1'b1;
        e.chk_tgt   = 1'b1;
        a           = in.rd1;
        b           = opb(in);
        f           = in.imm[5:0];
        e.wreg      = in.regdst ? in.rd : in.rb;
        e.wdata     = in.rd2;
        e.memtoreg  = in.memtoreg;
        e.regwrite  = in.regwrite;
        e.memread   = in.memread;
        e.memwrite  = in.memwrite;
        if (in.aluop == 2'b01) begin
            e.alu = a - b;
        end else if (in.aluop == 2'b10) begin
            case (f)
                6'b100000: e.alu = a + b;
                6'b100010: e.alu = a - b;
                6'b100100: e.alu = a & b;
                6'b100101: e.alu = a | b;
                6'b101010: e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default: begin
                    e.alu      = 32'd0;
                    e.regwrite = 1'b0;
                end
            endcase
        end else begin
            e.alu = a + b;
        end
        e.btgt = in.pc + 8'(f) * 8'd4;
        if (in.branch) begin
            e.btaken   = (in.rd1 == in.rd2);
            e.regwrite = 1'b0;
            e.memread  = 1'b0;
            e.memwrite = 1'b0;
        end
        return e;
    endfunction

    task automatic apply(input instr_t in);
        rd1 = in.rd1; rd2 = in.rd2; imm = in.imm; rb = in.rb; rd = in.rd; pc = in.pc;
        regdst = in.regdst; alusrc = in.alusrc; memtoreg = in.memtoreg; regwrite = in.regwrite;
        memread = in.memread; memwrite = in.memwrite; branch = in.branch; aluop = in.aluop;
    endtask

    task automatic step(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction; a mult is held for its whole occupancy (abort_at>0 resets mid-way)
    task automatic run_instr(input instr_t in, input int abort_at);
        exp_t e;
        apply(in);
        if (is_mult(in)) begin
            e = pending;
            e.stall = 1'b1;
            step(e);
            for (int k = 1; k <= 32; k++) begin
                if (k == abort_at) begin
                    rst = 1'b1;
                    step(zero_e);
                    rst = 1'b0;
                    pending = zero_e;
                    return;
                end
                e = '0;
                e.stall = 1'b1;
                step(e);
            end
            e          = '0;
            e.chk_data = 1'b1;
            e.alu      = in.rd1 * opb(in);
            e.wreg     = in.regdst ? in.rd : in.rb;
            e.memtoreg = in.memtoreg;
            e.regwrite = in.regwrite;
            e.memread  = in.memread;
            e.memwrite = in.memwrite;
            step(e);
            pending = '0;
        end else begin
            e = pending;
            e.stall = 1'b0;
            step(e);
            pending = model(in);
        end
    endtask

    function automatic instr_t gen_instr();
        instr_t in;
        int     sel;
        in.rd1 = $urandom;
        in.rd2 = ($urandom_range(0, 3) == 0) ? in.rd1 : $urandom;
        in.imm = $urandom;
        in.rb = 5'($urandom); in.rd = 5'($urandom); in.pc = 8'($urandom);
        in.regdst = 1'($urandom); in.alusrc = 1'($urandom); in.memtoreg = 1'($urandom);
        in.regwrite = 1'($urandom); in.memread = 1'($urandom); in.memwrite = 1'($urandom);
        in.branch = 1'b0;
        sel = $urandom_range(0, 19);
        if (sel < 6) begin
            in.aluop = 2'b00;
        end else if (sel < 8) begin
            in.aluop = 2'b01;
        end else if (sel < 9) begin
            in.aluop = 2'b11;
        end else if (sel < 15) begin
            in.aluop = 2'b10;
            in.alusrc = 1'b0;
            case ($urandom_range(0, 5))
                0: in.imm[5:0] = 6'b100000;
                1: in.imm[5:0] = 6'b100010;
                2: in.imm[5:0] = 6'b100100;
                3: in.imm[5:0] = 6'b100101;
                4: in.imm[5:0] = 6'b101010;
                default: in.imm[5:0] = 6'($urandom);
            endcase
        end else if (sel < 19) begin
            in.aluop = 2'b01; in.alusrc = 1'b0; in.branch = 1'b1;
        end else begin
            in.aluop = 2'b10; in.alusrc = 1'b0; in.imm[5:0] = 6'b011000;
            in.regdst = 1'b1; in.regwrite = 1'b1;
        end
        return in;
    endfunction

    initial begin
        instr_t in;
        zero_e           = '0;
        zero_e.chk_data  = 1'b1;
        zero_e.chk_wdata = 1'b1;
        zero_e.chk_tgt   = 1'b1;
        pending          = zero_e;
        rst = 1'b1;
        in = '0;
        apply(in);
        @(posedge clk);
        #1;
        step(zero_e);
        step(zero_e);
        rst = 1'b0;

        // LW-style address add
        in = '0; in.aluop = 2'b00; in.alusrc = 1'b1; in.rd1 = 32'h10; in.imm = 32'h4;
        in.rb = 5'd5; in.memread = 1'b1; in.memtoreg = 1'b1; in.regwrite = 1'b1;
        run_instr(in, 0);
        // slt signed: -1 < 1
        in = '0; in.aluop = 2'b10; in.rd1 = 32'hFFFF_FFFF; in.rd2 = 32'd1;
        in.imm = 32'h2A; in.regdst = 1'b1; in.rd = 5'd9; in.regwrite = 1'b1;
        run_instr(in, 0);
        // sub wraps: 0 - 1
        in.rd1 = 32'd0; in.imm = 32'h22;
        run_instr(in, 0);
        // BEQ taken, then not taken
        in = '0; in.aluop = 2'b01; in.branch = 1'b1; in.rd1 = 32'd7; in.rd2 = 32'd7;
        in.pc = 8'd8; in.imm = 32'd3; in.regwrite = 1'b1;
        run_instr(in, 0);
        in.rd2 = 32'd8;
        run_instr(in, 0);
        // mult 6*7 -> r3, then 0xFFFFFFFF*2
        in = '0; in.aluop = 2'b10; in.imm = 32'h18; in.rd1 = 32'd6; in.rd2 = 32'd7;
        in.regdst = 1'b1; in.rd = 5'd3; in.regwrite = 1'b1;
        run_instr(in, 0);
        in.rd1 = 32'hFFFF_FFFF; in.rd2 = 32'd2;
        run_instr(in, 0);
        // Reset in cycle 10 of a mult, then a plain add
        in.rd1 = 32'd123; in.rd2 = 32'd456;
        run_instr(in, 10);
        in = '0; in.aluop = 2'b00; in.rd1 = 32'd100; in.rd2 = 32'd23;
        in.rb = 5'd4; in.regwrite = 1'b1;
        run_instr(in, 0);

        for (int i = 0; i < 150; i++) begin
            run_instr(gen_instr(), 0);
        end

        // Flush the last result through the monitor
        in = '0;
        run_instr(in, 0);
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
